led_band_scan_sequencer: RTL and testbench

Generates the shift/latch timing for one LED band: `SCLK`, `LAT` and the `angle`/`row`/`color`/`bit_sel` address fields consumed by the band controller. It tracks the rotor angle from encoder ticks and an index pulse, and runs one greyscale scan per angle step. It also runs the function-control (FC) configuration shifts until the driver reports configured, and issues the buffer-swap `new_frame` pulse only at angle 0 so frames never tear.

---
 rtl/led_band_scan_sequencer_if.sv | 30 +++
 rtl/led_band_scan_sequencer.sv | 164 ++++++++++++++++
 tb/tb_led_band_scan_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_band_scan_sequencer_if.sv
// Signal bundle between the band scan sequencer and the band controller / rotor front end.
interface led_band_scan_sequencer_if #(
   parameter int ANGLE_WIDTH   = 7,
   parameter int ROW_WIDTH     = 5,
   parameter int BIT_SEL_WIDTH = 4
);
   logic                     angle_tick;
   logic                     index;
   logic                     frame_ready;
   logic                     fc_done;
   logic                     SCLK;
   logic                     LAT;
   logic [ANGLE_WIDTH-1:0]   angle;
   logic [ROW_WIDTH-1:0]     row;
   logic [1:0]               color;
   logic [BIT_SEL_WIDTH-1:0] bit_sel;
   logic                     new_frame;
   logic                     busy;
   logic [7:0]               drop_cnt;

   modport master (
      input  angle_tick, index, frame_ready, fc_done,
      output SCLK, LAT, angle, row, color, bit_sel, new_frame, busy, drop_cnt
   );

   modport slave (
      output angle_tick, index, frame_ready, fc_done,
      input  SCLK, LAT, angle, row, color, bit_sel, new_frame, busy, drop_cnt
   );
endinterface

// File: rtl/led_band_scan_sequencer.sv
// Shift/latch sequencer for one LED band: angle tracking, FC configuration shifts,
// greyscale scans per angle step and tear-free buffer swap at angle 0.
module led_band_scan_sequencer #(
   parameter int NB_LED_COLUMN = 32,
   parameter int BIT_PER_COLOR = 8,
   parameter int NB_0_LSB      = 1,
   parameter int NB_ANGLES     = 128,
   parameter int FC_LENGTH     = 48
) (
   input  logic                      clk,
   input  logic                      rst,
   led_band_scan_sequencer_if.master bus
);
   localparam int ROW_WIDTH     = $clog2(NB_LED_COLUMN);
   localparam int NB_SLOT_BITS  = BIT_PER_COLOR + NB_0_LSB;
   localparam int BIT_SEL_WIDTH = $clog2(NB_SLOT_BITS);
   localparam int ANGLE_WIDTH   = $clog2(NB_ANGLES);
   localparam int GS_SLOTS      = NB_LED_COLUMN * 3 * NB_SLOT_BITS;
   localparam int MAX_SLOTS     = (GS_SLOTS > FC_LENGTH) ? GS_SLOTS : FC_LENGTH;
   localparam int CNT_W         = $clog2(MAX_SLOTS);

   localparam logic [CNT_W-1:0]         GS_LAST = CNT_W'(GS_SLOTS - 1);
   localparam logic [CNT_W-1:0]         FC_LAST = CNT_W'(FC_LENGTH - 1);
   localparam logic [ROW_WIDTH-1:0]     ROW_TOP = ROW_WIDTH'(NB_LED_COLUMN - 1);
   localparam logic [BIT_SEL_WIDTH-1:0] BIT_TOP = BIT_SEL_WIDTH'(NB_SLOT_BITS - 1);
   localparam logic [ANGLE_WIDTH-1:0]   ANG_TOP = ANGLE_WIDTH'(NB_ANGLES - 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] FC_SHIFT = 2'd1;
   localparam logic [1:0] GS_SHIFT = 2'd2;
   localparam logic [1:0] LATCH    = 2'd3;

   logic [1:0]               state, next_state, phase;
   logic [CNT_W-1:0]         slot_cnt;
   logic                     lat_fc, pend, swap_pend;
   logic [ANGLE_WIDTH-1:0]   ang, ang_next, pend_ang, gs_ang, angle_r;
   logic [ROW_WIDTH-1:0]     row_r;
   logic [1:0]               color_r;
   logic [BIT_SEL_WIDTH-1:0] bit_r;
   logic                     sclk_r, lat_r, new_frame_r, busy_r;
   logic [7:0]               drop_r;
   logic                     req, shifting, slot_end, scan_end, decide;
   logic                     take_req, start_fc, start_gs, queue_req, drop;

   always_comb begin
      req      = bus.index | bus.angle_tick;
      ang_next = ang;
      if (bus.index)
         ang_next = '0;
      else if (bus.angle_tick)
         ang_next = (ang == ANG_TOP) ? '0 : ang + ANGLE_WIDTH'(1);

      shifting = (state == FC_SHIFT) || (state == GS_SHIFT);
      slot_end = (phase == 2'd3);
      scan_end = slot_end && (((state == FC_SHIFT) && (slot_cnt == FC_LAST)) ||
                              ((state == GS_SHIFT) && (slot_cnt == GS_LAST)));
      // IDLE decides every cycle; LATCH decides once, in its last phase
      decide   = (state == IDLE) || ((state == LATCH) && slot_end);
      take_req = req && ((state == IDLE) || !lat_fc);
      start_fc = decide && !bus.fc_done;
      start_gs = decide && bus.fc_done && (pend || take_req);
      gs_ang   = take_req ? ang_next : pend_ang;
      queue_req = req && !(start_gs && take_req) &&
                  ((state == GS_SHIFT) || ((state == LATCH) && !lat_fc));
      drop     = pend && (queue_req || (start_gs && take_req));

      next_state = state;
      if (start_fc)
         next_state = FC_SHIFT;
      else if (start_gs)
         next_state = GS_SHIFT;
      else if (decide)
         next_state = IDLE;
      else if (scan_end)
         next_state = LATCH;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FC_SHIFT;
         phase       <= 2'd0;
         slot_cnt    <= '0;
         lat_fc      <= 1'b0;
         ang         <= '0;
         pend        <= 1'b0;
         pend_ang    <= '0;
         swap_pend   <= 1'b0;
         angle_r     <= '0;
         row_r       <= '0;
         color_r     <= 2'd0;
         bit_r       <= '0;
         sclk_r      <= 1'b0;
         lat_r       <= 1'b0;
         new_frame_r <= 1'b0;
         busy_r      <= 1'b0;
         drop_r      <= 8'd0;
      end else begin
         state       <= next_state;
         phase       <= (state == IDLE) ? 2'd0 : phase + 2'd1;
         ang         <= ang_next;
         busy_r      <= (next_state != IDLE);
         // strobes are registered one phase ahead so they align with the slot phase
         sclk_r      <= shifting && (phase == 2'd1);
         lat_r       <= (state == LATCH) && ((phase == 2'd0) || (phase == 2'd1));
         new_frame_r <= 1'b0;
         if (bus.frame_ready)
            swap_pend <= 1'b1;

         if (start_fc || start_gs || scan_end)
            slot_cnt <= '0;
         else if (shifting && slot_end)
            slot_cnt <= slot_cnt + CNT_W'(1);

         if (scan_end)
            lat_fc <= (state == FC_SHIFT);

         if (start_gs) begin
            angle_r <= gs_ang;
            row_r   <= ROW_TOP;
            color_r <= 2'd2;
            bit_r   <= BIT_TOP;
            pend    <= 1'b0;
            if ((gs_ang == '0) && (swap_pend || bus.frame_ready)) begin
               new_frame_r <= 1'b1;
               swap_pend   <= 1'b0;
            end
         end else if (start_fc) begin
            angle_r <= '0;
            row_r   <= '0;
            color_r <= 2'd0;
            bit_r   <= '0;
         end else if ((state == GS_SHIFT) && slot_end && !scan_end) begin
            if (bit_r != '0) begin
               bit_r <= bit_r - BIT_SEL_WIDTH'(1);
            end else begin
               bit_r <= BIT_TOP;
               if (color_r != 2'd0) begin
                  color_r <= color_r - 2'd1;
               end else begin
                  color_r <= 2'd2;
                  row_r   <= row_r - ROW_WIDTH'(1);
               end
            end
         end

         if (queue_req) begin
            pend     <= 1'b1;
            pend_ang <= ang_next;
         end
         if (drop && (drop_r != 8'hFF))
            drop_r <= drop_r + 8'd1;
      end
   end

   assign bus.SCLK      = sclk_r;
   assign bus.LAT       = lat_r;
   assign bus.angle     = angle_r;
   assign bus.row       = row_r;
   assign bus.color     = color_r;
   assign bus.bit_sel   = bit_r;
   assign bus.new_frame = new_frame_r;
   assign bus.busy      = busy_r;
   assign bus.drop_cnt  = drop_r;
endmodule

// File: tb/tb_led_band_scan_sequencer.sv
// Scoreboard bench for led_band_scan_sequencer with small parameters (2 LEDs, 3-bit slots, 4 angles, FC of 3).
module tb_led_band_scan_sequencer;
   localparam int NB_LED_COLUMN = 2;
   localparam int BIT_PER_COLOR = 2;
   localparam int NB_0_LSB      = 1;
   localparam int NB_ANGLES     = 4;
   localparam int FC_LENGTH     = 3;

   logic        clk = 1'b0;
   logic        rst;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          nf_count = 0;
   bit          sb_en = 1'b1;
   logic [19:0] sbq[$];

   led_band_scan_sequencer_if #(.ANGLE_WIDTH(2), .ROW_WIDTH(1), .BIT_SEL_WIDTH(2)) bus();

   led_band_scan_sequencer #(
      .NB_LED_COLUMN(NB_LED_COLUMN),
      .BIT_PER_COLOR(BIT_PER_COLOR),
      .NB_0_LSB     (NB_0_LSB),
      .NB_ANGLES    (NB_ANGLES),
      .FC_LENGTH    (FC_LENGTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // one nibble each: is_lat, angle, row, color, bit_sel
   function automatic logic [19:0] pk(input int l, input int a, input int r, input int c, input int b);
      return {4'(l), 4'(a), 4'(r), 4'(c), 4'(b)};
   endfunction

   task automatic push_gs(input int a, input int nslots);
      int k = 0;
      for (int r = NB_LED_COLUMN - 1; r >= 0; r--)
         for (int c = 2; c >= 0; c--)
            for (int b = BIT_PER_COLOR + NB_0_LSB - 1; b >= 0; b--) begin
               if (k < nslots) sbq.push_back(pk(0, a, r, c, b));
               k++;
            end
      if (nslots >= k) sbq.push_back(pk(1, a, 0, 0, 0));
   endtask

   task automatic push_fc();
      for (int i = 0; i < FC_LENGTH; i++) sbq.push_back(pk(0, 0, 0, 0, 0));
      sbq.push_back(pk(1, 0, 0, 0, 0));
   endtask

   task automatic tick();
      bus.angle_tick = 1'b1;
      @(negedge clk);
      bus.angle_tick = 1'b0;
   endtask

   task automatic idx();
      bus.index = 1'b1;
      @(negedge clk);
      bus.index = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((bus.busy !== 1'b0) && (n < 2000)) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   // monitor: pops one expectation per SCLK or LAT rising edge
   initial begin
      logic        sclk_prev, lat_prev;
      int          sclk_len, lat_len;
      logic [19:0] obs, e;
      sclk_prev = 1'b0; lat_prev = 1'b0; sclk_len = 0; lat_len = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            sclk_prev = 1'b0; lat_prev = 1'b0; sclk_len = 0; lat_len = 0;
         end else begin
            if (bus.SCLK) sclk_len++;
            if (bus.LAT) lat_len++;
            if (sb_en && ((bus.SCLK && !sclk_prev) || (bus.LAT && !lat_prev))) begin
               obs = pk(bus.LAT ? 1 : 0, int'(bus.angle), int'(bus.row), int'(bus.color), int'(bus.bit_sel));
               if (sbq.size() == 0) chk("sb_unexpected_pulse", 32'(obs), 32'hFFFFF);
               else begin
                  e = sbq.pop_front();
                  chk("sb_pulse", 32'(obs), 32'(e));
               end
            end
            if (!bus.SCLK && sclk_prev) begin chk("sclk_width", sclk_len, 1); sclk_len = 0; end
            if (!bus.LAT && lat_prev) begin chk("lat_width", lat_len, 2); lat_len = 0; end
            if (bus.new_frame) begin
               nf_count++;
               chk("nf_addr", 32'(pk(0, int'(bus.angle), int'(bus.row), int'(bus.color), int'(bus.bit_sel))),
                   32'(pk(0, 0, 1, 2, 2)));
            end
            sclk_prev = bus.SCLK;
            lat_prev  = bus.LAT;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, actual %0d checks, required completion", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int first;
      int t0;
      int exp3[4] = '{1, 2, 3, 0};
      rst = 1'b1;
      bus.angle_tick = 1'b0; bus.index = 1'b0; bus.frame_ready = 1'b0; bus.fc_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_outputs", 32'({bus.SCLK, bus.LAT, bus.new_frame, bus.busy, bus.angle, bus.row,
                              bus.color, bus.bit_sel, bus.drop_cnt}), 32'd0);

      // 1: three FC scans with fc_done low, ticks and index ignored
      push_fc(); push_fc(); push_fc();
      rst = 1'b0;
      first = -1;
      for (int i = 0; i < 40; i++) begin
         if (bus.SCLK && (first < 0)) first = i;
         bus.angle_tick = (i == 5) || (i == 21) || (i == 30);
         bus.index      = (i == 10);
         @(negedge clk);
      end
      bus.angle_tick = 1'b0; bus.index = 1'b0;
      bus.fc_done = 1'b1;
      chk("fc_first_sclk", first, 2);
      wait_idle("t1");
      chk("t1_drop", 32'(bus.drop_cnt), 32'd0);
      chk("t1_drain", sbq.size(), 0);

      // 2: index starts a single GS scan at angle 0
      push_gs(0, 18);
      t0 = cyc;
      idx();
      chk("t2_start", 32'(pk(int'(bus.busy), int'(bus.angle), int'(bus.row), int'(bus.color), int'(bus.bit_sel))),
          32'(pk(1, 0, 1, 2, 2)));
      chk("t2_sclk_t1", 32'(bus.SCLK), 32'd0);
      @(negedge clk);
      chk("t2_sclk_t2", 32'(bus.SCLK), 32'd0);
      @(negedge clk);
      chk("t2_sclk_t3", 32'(bus.SCLK), 32'd1);
      wait_idle("t2");
      chk("t2_busy_len", cyc - t0 - 1, 76);
      chk("t2_drain", sbq.size(), 0);

      // 3: ticks 100 cycles apart wrap the angle 1,2,3,0
      for (int k = 0; k < 4; k++) begin
         push_gs(exp3[k], 18);
         tick();
         repeat (99) @(negedge clk);
         chk("t3_idle", 32'(bus.busy), 32'd0);
      end
      chk("t3_drain", sbq.size(), 0);
      chk("t3_no_nf", nf_count, 0);

      // 4: ticks during a scan -> one pending scan at the last angle, one drop
      push_gs(1, 18); push_gs(3, 18);
      t0 = cyc;
      tick();
      repeat (3) @(negedge clk);
      tick();
      repeat (3) @(negedge clk);
      tick();
      wait_idle("t4");
      chk("t4_busy_len", cyc - t0 - 1, 152);
      chk("t4_drop", 32'(bus.drop_cnt), 32'd1);
      chk("t4_drain", sbq.size(), 0);

      sb_en = 1'b0;
      bus.angle_tick = 1'b1;
      repeat (301) @(negedge clk);
      bus.angle_tick = 1'b0;
      wait_idle("t4_flood");
      chk("t4_drop_sat", 32'(bus.drop_cnt), 32'd255);
      sb_en = 1'b1;
      chk("t5_no_nf_before", nf_count, 0);

      // 5: frame_ready at angle 2 -> exactly one swap at the next angle-0 scan
      push_gs(0, 18); idx(); wait_idle("t5a");
      push_gs(1, 18); tick(); wait_idle("t5b");
      push_gs(2, 18); tick();
      repeat (10) @(negedge clk);
      bus.frame_ready = 1'b1;
      @(negedge clk);
      bus.frame_ready = 1'b0;
      wait_idle("t5c");
      chk("t5_nf_not_yet", nf_count, 0);
      push_gs(3, 18); tick(); wait_idle("t5d");
      push_gs(0, 18); tick();
      chk("t5_nf_start", 32'(bus.new_frame), 32'd1);
      @(negedge clk);
      chk("t5_nf_width", 32'(bus.new_frame), 32'd0);
      wait_idle("t5e");
      for (int k = 0; k < 4; k++) begin
         push_gs(exp3[k], 18);
         tick();
         wait_idle("t5f");
      end
      chk("t5_nf_once", nf_count, 1);
      chk("t5_drain", sbq.size(), 0);

      // 6: asynchronous reset at slot 5 phase 2 of a GS scan, then FC first
      push_gs(1, 6);
      tick();
      repeat (22) @(negedge clk);
      chk("t6_sclk_pre", 32'(bus.SCLK), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_outputs", 32'({bus.SCLK, bus.LAT, bus.new_frame, bus.busy, bus.angle, bus.row,
                                 bus.color, bus.bit_sel, bus.drop_cnt}), 32'd0);
      chk("t6_partial_drain", sbq.size(), 0);
      push_fc();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("t6_busy_after_rst", 32'(bus.busy), 32'd1);
      wait_idle("t6");
      chk("t6_drain", sbq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
